// File: rtl/nmr_bstrm_sram_arb.sv
// Round-robin arbiter sharing one SRAM read port between N_REQ bitstream controllers.
// One read issued per cycle; read data is routed back to its owner with a one-hot RVALID.
module nmr_bstrm_sram_arb #(
  parameter int N_REQ             = 4,
  parameter int SRAM_ADDR_WIDTH   = 8,
  parameter int SRAM_DAT_WIDTH    = 128,
  parameter int SRAM_BYTEEN_WIDTH = 16,
  parameter int RD_LAT            = 1
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               ARB_EN,
  input  logic [N_REQ-1:0]                   REQ,
  input  logic [N_REQ*SRAM_ADDR_WIDTH-1:0]   REQ_ADDR,
  output logic [N_REQ-1:0]                   GNT,
  output logic [N_REQ-1:0]                   RVALID,
  output logic [SRAM_DAT_WIDTH-1:0]          RD_DAT,
  output logic                               BUSY,
  output logic [SRAM_ADDR_WIDTH-1:0]         SRAM_ADDR,
  output logic                               SRAM_CS,
  output logic                               SRAM_CLKEN,
  output logic                               SRAM_WR,
  output logic [SRAM_DAT_WIDTH-1:0]          SRAM_WR_DAT,
  output logic [SRAM_BYTEEN_WIDTH-1:0]       SRAM_BYTEEN,
  input  logic [SRAM_DAT_WIDTH-1:0]          SRAM_RD_DAT
);

  localparam int AW = SRAM_ADDR_WIDTH;
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e                     state_q, state_d;
  logic [IW-1:0]              ptr_q, ptr_d;
  logic [IW-1:0]              gid_q, gid_d;
  logic [N_REQ-1:0]           gnt_q, gnt_d;
  logic                       cs_q, cs_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic [RD_LAT-1:0]          pv_q, pv_d;
  logic [RD_LAT-1:0][IW-1:0]  pid_q, pid_d;

  logic [N_REQ-1:0]           eligible;
  logic [IW-1:0]              win_id;
  logic                       win_found;
  logic                       arb_go;
  logic                       in_flight;

  function automatic logic [IW-1:0] wrap_idx(input int unsigned v);
    return IW'(v % N_REQ);
  endfunction

  // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    eligible  = REQ & ~gnt_q;
    win_found = 1'b0;
    win_id    = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && eligible[wrap_idx(32'(ptr_q) + 32'(k))]) begin
        win_found = 1'b1;
        win_id    = wrap_idx(32'(ptr_q) + 32'(k));
      end
    end
    arb_go = ARB_EN && win_found;

    gnt_d = '0;
    if (arb_go) gnt_d[win_id] = 1'b1;
    cs_d   = arb_go;
    addr_d = arb_go ? REQ_ADDR[win_id*AW +: AW] : addr_q;
    gid_d  = arb_go ? win_id : gid_q;
    ptr_d  = arb_go ? wrap_idx(32'(win_id) + 32'd1) : ptr_q;
  end

  // Return pipeline: stage 0 takes the read issued this cycle; the last stage drives RVALID.
  always_comb begin
    pv_d      = '0;
    pid_d     = '0;
    pv_d[0]   = cs_q;
    pid_d[0]  = gid_q;
    for (int k = 1; k < RD_LAT; k++) begin
      pv_d[k]  = pv_q[k-1];
      pid_d[k] = pid_q[k-1];
    end

    // Reads that will still be outstanding after this edge; the returning stage is excluded.
    in_flight = cs_q;
    for (int k = 0; k < RD_LAT - 1; k++) in_flight = in_flight | pv_q[k];

    RVALID = '0;
    if (pv_q[RD_LAT-1]) RVALID[pid_q[RD_LAT-1]] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ARB_EN && (|REQ)) state_d = ST_RUN;
      ST_RUN:   if (!arb_go) state_d = in_flight ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: begin
        if (arb_go)          state_d = ST_RUN;
        else if (!in_flight) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      gnt_q   <= '0;
      cs_q    <= 1'b0;
      addr_q  <= '0;
      // NOTE: the return pipeline is reset so reads granted before reset never report RVALID.
      pv_q    <= '0;
      pid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      gnt_q   <= gnt_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      pv_q    <= pv_d;
      pid_q   <= pid_d;
    end
  end

  assign GNT         = gnt_q;
  assign SRAM_CS     = cs_q;
  assign SRAM_ADDR   = addr_q;
  assign BUSY        = (state_q != ST_IDLE);
  assign RD_DAT      = SRAM_RD_DAT;
  assign SRAM_CLKEN  = 1'b1;
  assign SRAM_WR     = 1'b0;
  assign SRAM_WR_DAT = '0;
  assign SRAM_BYTEEN = '1;

endmodule
